// File: rtl/stop_writer.sv
`timescale 1ns/1ps
// Write side of the row-stop table: latches the ball X into the row the ball sits on
// when stop is pressed, tracks filled rows, scores alignment and flags game over.
module stop_writer #(
  parameter int ROW1     = 110,
  parameter int ROW2     = 180,
  parameter int ROW3     = 250,
  parameter int ROW4     = 320,
  parameter int ROW5     = 390,
  parameter int TOL      = 16,
  parameter int LOCK_CYC = 1000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       Reset,
  input  logic       clear,
  input  logic       stop_req,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  output logic [9:0] stopX1,
  output logic [9:0] stopX2,
  output logic [9:0] stopX3,
  output logic [9:0] stopX4,
  output logic [9:0] stopX5,
  output logic [4:0] filled,
  output logic [2:0] cur_row,
  output logic       row_done,
  output logic       miss,
  output logic       game_over
);

  typedef enum logic [1:0] {ARMED, CAPTURE, LOCKOUT, OVER} state_t;

  localparam int            CW        = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYC - 1);

  state_t        state_q, state_d;
  logic [2:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    x_q, x_d;
  logic [2:0]    k_q, k_d;
  logic [9:0]    stop_q [5];
  logic [9:0]    stop_d [5];
  logic [4:0]    filled_q, filled_d;
  logic [2:0]    cur_row_q, cur_row_d;
  logic          row_done_q, row_done_d;
  logic          miss_q, miss_d;
  logic          over_q, over_d;

  logic              press;
  logic [2:0]        row_k;
  logic              row_free;
  logic [9:0]        below_x;
  logic              below_valid;
  logic signed [10:0] diff;
  logic [10:0]       abs_d;
  logic              is_miss;

  // Rising edge of the synchronised button: sync_q[1] is the second stage, sync_q[2] its history.
  assign press = sync_q[1] & ~sync_q[2];

  always_comb begin
    row_k    = 3'd0;
    row_free = 1'b0;
    if (BallY == 10'(ROW1)) begin
      row_k = 3'd1; row_free = ~filled_q[0];
    end else if (BallY == 10'(ROW2)) begin
      row_k = 3'd2; row_free = ~filled_q[1];
    end else if (BallY == 10'(ROW3)) begin
      row_k = 3'd3; row_free = ~filled_q[2];
    end else if (BallY == 10'(ROW4)) begin
      row_k = 3'd4; row_free = ~filled_q[3];
    end else if (BallY == 10'(ROW5)) begin
      row_k = 3'd5; row_free = ~filled_q[4];
    end
  end

  // Row k is scored against row k+1; row 5 has nothing below and always hits.
  always_comb begin
    below_x     = '0;
    below_valid = 1'b0;
    case (k_q)
      3'd1: begin below_x = stop_q[1]; below_valid = filled_q[1]; end
      3'd2: begin below_x = stop_q[2]; below_valid = filled_q[2]; end
      3'd3: begin below_x = stop_q[3]; below_valid = filled_q[3]; end
      3'd4: begin below_x = stop_q[4]; below_valid = filled_q[4]; end
      default: ;
    endcase
    diff    = $signed({1'b0, x_q}) - $signed({1'b0, below_x});
    abs_d   = (diff < 0) ? 11'(-diff) : 11'(diff);
    is_miss = below_valid && (abs_d > 11'(TOL));
  end

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[1], sync_q[0], stop_req};
    cnt_d      = cnt_q;
    x_d        = x_q;
    k_d        = k_q;
    stop_d     = stop_q;
    filled_d   = filled_q;
    cur_row_d  = cur_row_q;
    row_done_d = 1'b0;
    miss_d     = miss_q;
    over_d     = over_q;

    case (state_q)
      ARMED: begin
        if (press && (row_k != 3'd0) && row_free) begin
          x_d     = BallX;
          k_d     = row_k;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        for (int i = 0; i < 5; i++) begin
          if (k_q == 3'(i + 1)) begin
            stop_d[i]   = x_q;
            filled_d[i] = 1'b1;
          end
        end
        cur_row_d  = k_q;
        row_done_d = 1'b1;
        if (is_miss) miss_d = 1'b1;
        if (is_miss || (filled_d == 5'b11111)) begin
          over_d  = 1'b1;
          state_d = OVER;
        end else begin
          cnt_d   = LOCK_LOAD;
          state_d = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (cnt_q == '0) state_d = ARMED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      OVER: ;
      default: state_d = ARMED;
    endcase

    // New-game clear overrides anything decided above on the same edge.
    if (clear) begin
      state_d    = ARMED;
      sync_d     = '0;
      cnt_d      = '0;
      x_d        = '0;
      k_d        = '0;
      stop_d     = '{default: '0};
      filled_d   = '0;
      cur_row_d  = '0;
      row_done_d = 1'b0;
      miss_d     = 1'b0;
      over_d     = 1'b0;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset) begin
    if (Reset) begin
      state_q    <= ARMED;
      sync_q     <= '0;
      cnt_q      <= '0;
      x_q        <= '0;
      k_q        <= '0;
      stop_q     <= '{default: '0};
      filled_q   <= '0;
      cur_row_q  <= '0;
      row_done_q <= 1'b0;
      miss_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      k_q        <= k_d;
      stop_q     <= stop_d;
      filled_q   <= filled_d;
      cur_row_q  <= cur_row_d;
      row_done_q <= row_done_d;
      miss_q     <= miss_d;
      over_q     <= over_d;
    end
  end

  assign stopX1    = stop_q[0];
  assign stopX2    = stop_q[1];
  assign stopX3    = stop_q[2];
  assign stopX4    = stop_q[3];
  assign stopX5    = stop_q[4];
  assign filled    = filled_q;
  assign cur_row   = cur_row_q;
  assign row_done  = row_done_q;
  assign miss      = miss_q;
  assign game_over = over_q;

endmodule
